// File: rtl/uart_tx_fifo_cfg_pkg.sv
// Helpers for the UART transmitter.
//   MAX_DATA_WIDTH : widest supported data field
//   parity_enabled : true when a parity bit is appended
//   parity_bit     : parity bit value for a zero-extended data word
package uart_tx_fifo_cfg_pkg;

   localparam int unsigned MAX_DATA_WIDTH = 9;

   function automatic logic parity_enabled(utils::parity_t p);
      return (p == utils::EVEN) || (p == utils::ODD);
   endfunction

   // Zero padding above DATA_WIDTH does not change the XOR.
   function automatic logic parity_bit(logic [MAX_DATA_WIDTH-1:0] d, utils::parity_t p);
      return (p == utils::ODD) ? ~(^d) : (^d);
   endfunction

endpackage

// File: rtl/utils.sv
// Shared project constants and types.
//   CLK_PER_HALF_BIT : board clocks per half UART bit
//   DEFAULT_DIV      : reset-time divisor (clocks per bit minus 1)
//   parity_t         : UART parity selection
package utils;

   localparam int unsigned CLK_PER_HALF_BIT = 217;
   localparam int unsigned DEFAULT_DIV      = CLK_PER_HALF_BIT * 2 - 1;

   // Encoding 3 is unused and behaves as NONE.
   typedef enum logic [1:0] {
      NONE = 2'd0,
      EVEN = 2'd1,
      ODD  = 2'd2
   } parity_t;

endpackage

// File: rtl/uart_tx_fifo_cfg_if.sv
// Producer-facing bus of the UART transmitter.
//   cfg_div/cfg_parity/cfg_stop2 : frame format
//   s_data/s_valid/s_ready       : push handshake
//   tx_busy/fifo_level           : status
//   txd                          : serial line
interface uart_tx_fifo_cfg_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned DIV_WIDTH  = 16
);
   localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);

   logic [DIV_WIDTH-1:0]  cfg_div;
   utils::parity_t        cfg_parity;
   logic                  cfg_stop2;
   logic [DATA_WIDTH-1:0] s_data;
   logic                  s_valid;
   logic                  s_ready;
   logic                  tx_busy;
   logic [LVL_W-1:0]      fifo_level;
   logic                  txd;

   modport master (
      output cfg_div, cfg_parity, cfg_stop2, s_data, s_valid,
      input  s_ready, tx_busy, fifo_level, txd
   );

   modport slave (
      input  cfg_div, cfg_parity, cfg_stop2, s_data, s_valid,
      output s_ready, tx_busy, fifo_level, txd
   );
endinterface

// File: rtl/uart_fifo.sv
// Synchronous FIFO with registered pointers.
//   clk, rst : clock, async active-high reset
//   push_i/data_i : write (ignored when full)
//   pop_i/data_o  : read head (ignored when empty)
//   full_o/empty_o/level_o : occupancy
module uart_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push_i,
   input  logic [WIDTH-1:0]             data_i,
   input  logic                         pop_i,
   output logic [WIDTH-1:0]             data_o,
   output logic                         full_o,
   output logic                         empty_o,
   output logic [$clog2(DEPTH+1)-1:0]   level_o
);
   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned LVL_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]      used;
   logic             push_ok, pop_ok;

   // Extra pointer bit distinguishes full from empty.
   assign used    = wr_q - rd_q;
   assign full_o  = (used == (AW+1)'(DEPTH));
   assign empty_o = (wr_q == rd_q);
   assign level_o = LVL_W'(used);
   assign data_o  = mem_q[rd_q[AW-1:0]];

   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (push_ok) wr_d = wr_q + 1'b1;
      if (pop_ok)  rd_d = rd_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   // Storage needs no reset; pointers define validity.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_q[AW-1:0]] <= data_i;
   end
endmodule

// File: rtl/uart_tx_fifo_cfg.sv
// UART transmitter with transmit FIFO and per-frame latched format.
//   clk, rst : clock, async active-high reset
//   bus      : config, push handshake, status and txd (slave side)
module uart_tx_fifo_cfg
   import utils::*;
   import uart_tx_fifo_cfg_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned DIV_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   uart_tx_fifo_cfg_if.slave    bus
);
   localparam int unsigned IDX_W = $clog2(DATA_WIDTH);
   localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t                state_q, state_d;
   logic [DIV_WIDTH-1:0]  timer_q, timer_d;
   logic [DIV_WIDTH-1:0]  div_q, div_d;
   logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   parity_t               par_q, par_d;
   logic                  stop2_q, stop2_d;
   logic                  stop_cnt_q, stop_cnt_d;
   logic                  txd_q, txd_d;
   logic                  busy_q, busy_d;

   logic [DATA_WIDTH-1:0] fifo_dout;
   logic                  fifo_full, fifo_empty;
   logic [LVL_W-1:0]      fifo_level;
   logic                  push, pop, load, bit_tc;

   assign push = bus.s_valid && !fifo_full;

   uart_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .data_i  (bus.s_data),
      .pop_i   (pop),
      .data_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (fifo_level)
   );

   assign bus.s_ready    = !fifo_full;
   assign bus.fifo_level = fifo_level;
   assign bus.txd        = txd_q;
   assign bus.tx_busy    = busy_q;

   assign bit_tc = (timer_q == div_q);

   // Next-state, frame sequencing and registered line value.
   always_comb begin
      state_d    = state_q;
      timer_d    = bit_tc ? '0 : timer_q + 1'b1;
      div_d      = div_q;
      bit_idx_d  = bit_idx_q;
      data_d     = data_q;
      par_d      = par_q;
      stop2_d    = stop2_q;
      stop_cnt_d = stop_cnt_q;
      load       = 1'b0;
      pop        = 1'b0;

      case (state_q)
         IDLE: begin
            timer_d = '0;
            if (!fifo_empty) load = 1'b1;
         end
         START: begin
            if (bit_tc) begin
               state_d   = DATA;
               bit_idx_d = '0;
            end
         end
         DATA: begin
            if (bit_tc) begin
               if (bit_idx_q == IDX_W'(DATA_WIDTH - 1)) begin
                  state_d    = parity_enabled(par_q) ? PARITY : STOP;
                  stop_cnt_d = 1'b0;
               end else begin
                  bit_idx_d = bit_idx_q + 1'b1;
               end
            end
         end
         PARITY: begin
            if (bit_tc) begin
               state_d    = STOP;
               stop_cnt_d = 1'b0;
            end
         end
         STOP: begin
            if (bit_tc) begin
               if (stop2_q && !stop_cnt_q) stop_cnt_d = 1'b1;
               else if (!fifo_empty)       load       = 1'b1;
               else                        state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Pop the head word and freeze the format for the whole frame.
      if (load) begin
         pop     = 1'b1;
         data_d  = fifo_dout;
         div_d   = bus.cfg_div;
         par_d   = bus.cfg_parity;
         stop2_d = bus.cfg_stop2;
         timer_d = '0;
         state_d = START;
      end

      case (state_d)
         START:   txd_d = 1'b0;
         DATA:    txd_d = data_d[bit_idx_d];
         PARITY:  txd_d = parity_bit(MAX_DATA_WIDTH'(data_d), par_d);
         default: txd_d = 1'b1;
      endcase

      // Busy covers a word that is still queued after this edge.
      busy_d = (state_d != IDLE) || push || (!fifo_empty && !pop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         timer_q    <= '0;
         div_q      <= '0;
         bit_idx_q  <= '0;
         data_q     <= '0;
         par_q      <= NONE;
         stop2_q    <= 1'b0;
         stop_cnt_q <= 1'b0;
         txd_q      <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         div_q      <= div_d;
         bit_idx_q  <= bit_idx_d;
         data_q     <= data_d;
         par_q      <= par_d;
         stop2_q    <= stop2_d;
         stop_cnt_q <= stop_cnt_d;
         txd_q      <= txd_d;
         busy_q     <= busy_d;
      end
   end
endmodule

// File: tb/tb_uart_tx_fifo_cfg.sv
// Directed self-checking bench for uart_tx_fifo_cfg (8 data bits, depth 4).
module tb_uart_tx_fifo_cfg;
   import utils::*;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   uart_tx_fifo_cfg_if #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .DIV_WIDTH(16)) bus ();

   uart_tx_fifo_cfg #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .DIV_WIDTH(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic push(input logic [7:0] d);
      bus.s_data  = d;
      bus.s_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.s_valid = 1'b0;
   endtask

   task automatic set_cfg(input logic [15:0] div, input parity_t par, input logic stop2);
      bus.cfg_div    = div;
      bus.cfg_parity = par;
      bus.cfg_stop2  = stop2;
   endtask

   // Waits for the start bit, then checks every clock of every bit (LSB first in bits).
   task automatic check_frame(input string name, input logic [15:0] bits, input int nbits,
                              input int clks, input int exp_wait);
      int   n;
      logic found;
      int   bad_bit;
      logic bad_val;
      found   = 1'b0;
      n       = 0;
      bad_bit = -1;
      bad_val = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin
         @(negedge clk);
         n++;
         if (bus.txd === 1'b0) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL %s_start: txd=%b, required a start bit within 400 cycles", name, bus.txd);
      end else begin
         if (exp_wait > 0) begin
            checks++;
            if (n !== exp_wait) begin
               errors++;
               $display("FAIL %s_latency: start bit after %0d cycles, required %0d", name, n, exp_wait);
            end
         end
         for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < clks; c++) begin
               if (!(b == 0 && c == 0)) @(negedge clk);
               if (bus.txd !== bits[b] && bad_bit < 0) begin
                  bad_bit = b;
                  bad_val = bus.txd;
               end
            end
         end
         checks++;
         if (bad_bit >= 0) begin
            errors++;
            $display("FAIL %s_bits: bit %0d txd=%b, required %b", name, bad_bit, bad_val, bits[bad_bit]);
         end
      end
   endtask

   task automatic check_idle(input string name, input int ncycles);
      logic low_seen;
      low_seen = 1'b0;
      for (int i = 0; i < ncycles; i++) begin
         @(negedge clk);
         if (bus.txd !== 1'b1) low_seen = 1'b1;
      end
      checks++;
      if (low_seen || bus.tx_busy !== 1'b0 || bus.fifo_level !== 3'd0) begin
         errors++;
         $display("FAIL %s_idle: low_seen=%b busy=%b level=%0d, required 0/0/0",
                  name, low_seen, bus.tx_busy, bus.fifo_level);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      set_cfg(16'd3, NONE, 1'b0);
      repeat (3) @(negedge clk);
      checks++;
      if (bus.txd !== 1'b1 || bus.tx_busy !== 1'b0 || bus.fifo_level !== 3'd0 || bus.s_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_values: txd=%b busy=%b level=%0d ready=%b, required 1/0/0/1",
                  bus.txd, bus.tx_busy, bus.fifo_level, bus.s_ready);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      set_cfg(16'd3, NONE, 1'b0);
      push(8'h55);
      checks++;
      if (bus.fifo_level !== 3'd1 || bus.tx_busy !== 1'b1) begin
         errors++;
         $display("FAIL basic_after_push: level=%0d busy=%b, required 1/1", bus.fifo_level, bus.tx_busy);
      end
      check_frame("basic_55", 16'h02AA, 10, 4, 2);
      checks++;
      if (bus.tx_busy !== 1'b1) begin
         errors++;
         $display("FAIL basic_busy_last_clk: busy=%b, required 1", bus.tx_busy);
      end
      @(negedge clk);
      checks++;
      if (bus.tx_busy !== 1'b0 || bus.txd !== 1'b1) begin
         errors++;
         $display("FAIL basic_busy_fall: busy=%b txd=%b, required 0/1", bus.tx_busy, bus.txd);
      end
      check_idle("basic", 5);
      // One clock per bit.
      set_cfg(16'd0, NONE, 1'b0);
      push(8'h55);
      check_frame("div0_55", 16'h02AA, 10, 1, 2);
      check_idle("div0", 5);
   endtask

   task automatic test_parity();
      set_cfg(16'd3, EVEN, 1'b0);
      push(8'h07);
      check_frame("even_07", 16'h060E, 11, 4, 2);
      check_idle("even", 5);
      set_cfg(16'd3, ODD, 1'b0);
      push(8'h07);
      check_frame("odd_07", 16'h040E, 11, 4, 2);
      check_idle("odd07", 5);
      push(8'h00);
      check_frame("odd_00", 16'h0600, 11, 4, 2);
      check_idle("odd00", 5);
   endtask

   task automatic test_back_to_back();
      set_cfg(16'd3, NONE, 1'b1);
      push(8'hA5);
      push(8'h3C);
      check_frame("stop2_a5", 16'h074A, 11, 4, 1);
      check_frame("stop2_3c", 16'h0678, 11, 4, 1);
      check_idle("stop2", 5);
   endtask

   task automatic test_fifo_full();
      logic [7:0] words [6];
      words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      set_cfg(16'd7, NONE, 1'b0);
      fork
         begin
            for (int i = 0; i < 6; i++) begin
               bus.s_data  = words[i];
               bus.s_valid = 1'b1;
               @(posedge clk);
               #1;
            end
            bus.s_valid = 1'b0;
            checks++;
            if (bus.fifo_level !== 3'd4 || bus.s_ready !== 1'b0) begin
               errors++;
               $display("FAIL full_level: level=%0d ready=%b, required 4/0", bus.fifo_level, bus.s_ready);
            end
         end
         begin
            for (int f = 0; f < 5; f++) begin
               check_frame($sformatf("full_f%0d", f), 16'({1'b1, words[f], 1'b0}), 10, 8, (f == 0) ? 0 : 1);
            end
         end
      join
      check_idle("full_no6th", 120);
   endtask

   task automatic test_reset_midframe();
      set_cfg(16'd3, NONE, 1'b0);
      push(8'hF7);
      push(8'h12);
      push(8'h34);
      // Now in start-bit clock 2; clock 18 is inside data bit 3.
      @(negedge clk);
      repeat (16) @(negedge clk);
      checks++;
      if (bus.txd !== 1'b0 || bus.fifo_level !== 3'd2) begin
         errors++;
         $display("FAIL rstmid_pre: txd=%b level=%0d, required 0/2", bus.txd, bus.fifo_level);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (bus.txd !== 1'b1 || bus.tx_busy !== 1'b0 || bus.fifo_level !== 3'd0 || bus.s_ready !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_async: txd=%b busy=%b level=%0d ready=%b, required 1/0/0/1",
                  bus.txd, bus.tx_busy, bus.fifo_level, bus.s_ready);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check_idle("rstmid_after", 60);
   endtask

   task automatic test_cfg_change();
      set_cfg(16'd3, NONE, 1'b0);
      push(8'h81);
      push(8'h07);
      set_cfg(16'd7, EVEN, 1'b0);
      check_frame("cfg_f1", 16'h0302, 10, 4, 1);
      check_frame("cfg_f2", 16'h060E, 11, 8, 1);
      check_idle("cfg", 5);
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_basic();
      test_parity();
      test_back_to_back();
      test_fifo_full();
      test_reset_midframe();
      test_cfg_change();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
